// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative multiply/divide owning HI/LO
// Single-cycle ops complete the cycle after issue; mult/div iterate WIDTH cycles.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid_out,
  output logic             busy,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic             div_by_zero
);

  localparam logic [3:0] C_AND  = 4'd0,  C_OR   = 4'd1,  C_ADD  = 4'd2,  C_XOR  = 4'd3;
  localparam logic [3:0] C_NOR  = 4'd4,  C_SLL  = 4'd5,  C_SUB  = 4'd6,  C_SLT  = 4'd7;
  localparam logic [3:0] C_SLTU = 4'd8,  C_SRL  = 4'd9,  C_SRA  = 4'd10, C_MFHI = 4'd11;
  localparam logic [3:0] C_MFLO = 4'd12, C_MUL  = 4'd13, C_DIV  = 4'd14, C_ILL  = 4'd15;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic             dbz_q, dbz_d;
  // Iteration working set: wh/wl hold partial product or remainder/quotient, m the fixed operand
  logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, m_q, m_d, asave_q, asave_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [3:0]       dec_ctrl;
  logic             dec_signed;
  logic [WIDTH-1:0] alu_res, a_mag, b_mag;
  logic [WIDTH:0]   madd, rsh;
  logic [WIDTH-1:0] mul_h, mul_l, div_h, div_l, dsub;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_u, prod_s;

  always_comb begin
    dec_ctrl   = C_ILL;
    dec_signed = 1'b0;
    case (aluOp)
      3'd0: dec_ctrl = C_ADD;
      3'd1: dec_ctrl = C_SUB;
      3'd2: begin
        case (funct)
          6'd0:         dec_ctrl = C_SLL;
          6'd2:         dec_ctrl = C_SRL;
          6'd3:         dec_ctrl = C_SRA;
          6'd16:        dec_ctrl = C_MFHI;
          6'd18:        dec_ctrl = C_MFLO;
          6'd24:        begin dec_ctrl = C_MUL; dec_signed = 1'b1; end
          6'd25:        dec_ctrl = C_MUL;
          6'd26:        begin dec_ctrl = C_DIV; dec_signed = 1'b1; end
          6'd27:        dec_ctrl = C_DIV;
          6'd32, 6'd33: dec_ctrl = C_ADD;
          6'd34, 6'd35: dec_ctrl = C_SUB;
          6'd36:        dec_ctrl = C_AND;
          6'd37:        dec_ctrl = C_OR;
          6'd38:        dec_ctrl = C_XOR;
          6'd39:        dec_ctrl = C_NOR;
          6'd42:        dec_ctrl = C_SLT;
          6'd43:        dec_ctrl = C_SLTU;
          default:      dec_ctrl = C_ILL;
        endcase
      end
      3'd3: dec_ctrl = C_OR;
      3'd4: dec_ctrl = C_AND;
      3'd5: dec_ctrl = C_SLT;
      3'd6: dec_ctrl = C_XOR;
      default: dec_ctrl = C_ILL;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      C_AND:  alu_res = a & b;
      C_OR:   alu_res = a | b;
      C_ADD:  alu_res = a + b;
      C_XOR:  alu_res = a ^ b;
      C_NOR:  alu_res = ~(a | b);
      C_SLL:  alu_res = a << shamt;
      C_SUB:  alu_res = a - b;
      C_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      C_SLTU: alu_res = WIDTH'(a < b);
      C_SRL:  alu_res = a >> shamt;
      C_SRA:  alu_res = $signed(a) >>> shamt;
      C_MFHI: alu_res = hi_q;
      C_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    a_mag = (dec_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (dec_signed && b[WIDTH-1]) ? -b : b;
    // Shift-add step: add multiplicand when LSB of multiplier is set, then shift right
    madd  = {1'b0, wh_q} + (wl_q[0] ? {1'b0, m_q} : '0);
    mul_h = madd[WIDTH:1];
    mul_l = {madd[0], wl_q[WIDTH-1:1]};
    // Restoring step: shift remainder left, keep difference only if divisor fits
    rsh    = {wh_q, wl_q[WIDTH-1]};
    div_ge = rsh >= {1'b0, m_q};
    dsub   = rsh[WIDTH-1:0] - m_q;
    div_h  = div_ge ? dsub : rsh[WIDTH-1:0];
    div_l  = {wl_q[WIDTH-2:0], div_ge};
    prod_u = {mul_h, mul_l};
    prod_s = neg_q ? -prod_u : prod_u;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    dbz_d     = dbz_q;
    wh_d      = wh_q;
    wl_d      = wl_q;
    m_d       = m_q;
    asave_d   = asave_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (dec_ctrl == C_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            wh_d    = '0;
            wl_d    = b_mag;
            m_d     = a_mag;
            neg_d   = dec_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end else if (dec_ctrl == C_DIV) begin
            state_d = S_DIV;
            cnt_d   = '0;
            wh_d    = '0;
            wl_d    = a_mag;
            m_d     = b_mag;
            asave_d = a;
            neg_d   = dec_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = dec_signed & a[WIDTH-1];
            dz_d    = (b == '0);
          end else begin
            result_d  = alu_res;
            valid_d   = 1'b1;
            ctrl_d    = dec_ctrl;
            illegal_d = (dec_ctrl == C_ILL);
            dbz_d     = 1'b0;
          end
        end
      end
      S_MUL: begin
        wh_d  = mul_h;
        wl_d  = mul_l;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          hi_d      = prod_s[2*WIDTH-1:WIDTH];
          lo_d      = prod_s[WIDTH-1:0];
          result_d  = prod_s[WIDTH-1:0];
          valid_d   = 1'b1;
          ctrl_d    = C_MUL;
          illegal_d = 1'b0;
          dbz_d     = 1'b0;
        end
      end
      S_DIV: begin
        wh_d  = div_h;
        wl_d  = div_l;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          valid_d   = 1'b1;
          ctrl_d    = C_DIV;
          illegal_d = 1'b0;
          dbz_d     = dz_q;
          if (dz_q) begin
            lo_d = '1;
            hi_d = asave_q;
          end else begin
            lo_d = neg_q ? -div_l : div_l;
            hi_d = rneg_q ? -div_h : div_h;
          end
          result_d = dz_q ? '1 : (neg_q ? -div_l : div_l);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ctrl_q    <= 4'd0;
      illegal_q <= 1'b0;
      dbz_q     <= 1'b0;
      wh_q      <= '0;
      wl_q      <= '0;
      m_q       <= '0;
      asave_q   <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      dbz_q     <= dbz_d;
      wh_q      <= wh_d;
      wl_q      <= wl_d;
      m_q       <= m_d;
      asave_q   <= asave_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign ready_out   = ~busy;
  assign result      = result_q;
  assign zero        = (result_q == '0);
  assign valid_out   = valid_q;
  assign alu_ctrl    = ctrl_q;
  assign illegal     = illegal_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the MIPS datapath. It combines ALU-control decoding (aluOp/funct) with a registered result path and an iterative multiply/divide engine that owns the HI/LO registers. It sits between the control unit/register file read stage and the writeback mux. It replaces purely combinational ALU-control decode with a valid/ready-handshaked execution unit.

## Interface
- WIDTH, 32, datapath width (≥ 8, power of 2)
- SHW, $clog2(WIDTH), shift-amount width (derived)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  operation issue strobe
- ready_out  out  1  unit can accept; = !busy
- aluOp  in  3  from control unit
- funct  in  6  instruction[5:0]
- shamt  in  SHW  shift amount
- a, b  in  WIDTH  operands (rs, rt / immediate)
- result  out  WIDTH  registered result
- zero  out  1  (result == 0), combinational from result
- valid_out  out  1  one-cycle completion pulse
- busy  out  1  multiply/divide in progress
- alu_ctrl  out  4  registered decoded op code (debug/branch use)
- illegal  out  1  qualified by valid_out: undefined aluOp/funct
- div_by_zero  out  1  qualified by valid_out: div/divu with b == 0

## Operation
- Accept when valid_in & ready_out at a rising edge; valid_in with ready_out low is ignored, with no side effects.
- aluOp decode:
  - 000 add
  - 001 sub
  - 010 R-type (use funct)
  - 011 or
  - 100 and
  - 101 slt
  - 110 xor
  - 111 illegal
- funct decode:
  - 0 sll, 2 srl, 3 sra (by shamt)
  - 16 mfhi, 18 mflo
  - 24 mult, 25 multu, 26 div, 27 divu
  - 32/33 add, 34/35 sub (no overflow trap)
  - 36 and, 37 or, 38 xor, 39 nor
  - 42 slt (signed), 43 sltu
  - any other value is illegal
- Illegal op: result = 0, illegal = 1 with valid_out, HI/LO unchanged.
- slt/sltu: result = 1 or 0, zero-extended to WIDTH.
- Arithmetic wraps modulo 2^WIDTH.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on accepted mult/multu.
  - IDLE → DIV on accepted div/divu.
  - MUL/DIV → IDLE when the iteration counter reaches WIDTH-1.
- Multiply: radix-2 shift-add on unsigned magnitudes, one bit per cycle, 2·WIDTH-bit product. Signed: negate the product if operand signs differ. {HI,LO} = product.
- Divide: restoring, one quotient bit per cycle, on magnitudes. Signed: quotient negated if signs differ; remainder takes the sign of a. LO = quotient, HI = remainder.
- Divide by zero: still runs WIDTH cycles. LO = all ones, HI = a, div_by_zero = 1.
- Signed MIN / -1: LO = MIN, HI = 0, no flag.
- Mult/div completion: result = new LO. HI/LO are written at the same edge that raises valid_out.
- Reset values: result 0, zero 1, valid_out 0, busy 0, ready_out 1, alu_ctrl 0, illegal 0, div_by_zero 0, HI 0, LO 0, state IDLE, counter 0.
- Reset mid-operation aborts the operation: no valid_out, HI/LO cleared.

## Timing
- Accept at edge N.
- Single-cycle ops (including mfhi/mflo and illegal): result and valid_out valid in cycle N+1. Back-to-back issue at full rate.
- Mult/div:
  - busy = 1 and ready_out = 0 in cycles N+1 … N+WIDTH.
  - valid_out = 1 in cycle N+WIDTH+1, with busy = 0 and ready_out = 1.
  - Total latency is WIDTH+1.
- An op accepted in the valid_out cycle of mult/div is legal. mfhi/mflo accepted there read the new HI/LO.
- result, alu_ctrl and flags hold their values until the next completion. valid_out is never high for two consecutive cycles for the same op.

## Test plan
- Reset, then R-type funct 34 with a=0x0000000A, b=0x00000003 → cycle later result=0x00000007, alu_ctrl=sub, valid_out pulse, zero=0.
- sra shamt=4 on a=0x80000000 → 0xF8000000; sltu a=0xFFFFFFFF, b=1 → 0; slt with same operands → 1; aluOp=111 → illegal=1, result=0.
- mult a=0xFFFFFFFE (-2), b=3 → busy 32 cycles, valid_out at N+33, LO=0xFFFFFFFA, HI=0xFFFFFFFF; then mfhi → 0xFFFFFFFF.
- div a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7, b=0 → LO=0xFFFFFFFF, HI=7, div_by_zero=1.
- valid_in held high during busy with add ops → ignored. An add issued in the mult valid_out cycle completes in the next cycle.
- reset asserted at cycle N+10 of a div → no valid_out, busy=0, HI=LO=0, ready_out=1 the cycle after reset deasserts; repeat at WIDTH=16 for multu 0xFFFF·0xFFFF → HI=0xFFFE, LO=0x0001 at N+17.
